fpu_sp_mul_operand_stage: RTL
=============================

// Module: fpu_sp_mul_operand_stage
// PURPOSE
//  Registered operand-staging stage directly upstream of fpu_sp_multiplier. Buffers IEEE-754
//  single-precision operand pairs in a small FIFO with valid/ready handshakes on both sides.
//  Classifies operands, flushes denormals to zero, and precomputes special-case results
//  (NaN/Inf/zero) so the multiplier datapath only sees normal operands.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of two, >= 2
//  FTZ       1   1: denormal inputs are flushed to signed zero; 0: passed through as normal
//  CNT_W     16  width of the saturating special-case counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  in_valid       in   1      operand pair valid
//  in_ready       out  1      stage can accept (= !full)
//  in_a, in_b     in   32     operands, IEEE-754 single-precision bit patterns
//  out_valid      out  1      head entry valid (= !empty)
//  out_ready      in   1      multiplier side consumes head
//  out_a, out_b   out  32     head operands after FTZ
//  out_special    out  1      head result is special; out_special_res is final, multiplier bypassed
//  out_special_res out 32     precomputed special result (0 when out_special=0)
//  special_cnt    out  CNT_W  saturating count of popped special entries
//  cnt_clr        in   1      synchronous clear of special_cnt
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, special_cnt=0; in_ready=1, out_valid=0.
//    Outputs out_a/out_b/out_special/out_special_res read 0 while empty. Reset mid-operation drops all entries.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready. Each moves one entry per cycle.
//  - Latency: entry pushed at edge N is visible on out_* after edge N (first-word latency 1 cycle).
//  - in_ready depends only on registered count; no combinational path from out_ready to in_ready.
//  - Full: push ignored (in_ready=0), pop allowed. Empty: pop ignored, push allowed.
//  - Simultaneous push+pop when neither full nor empty: count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Classification at push time (stored per entry): ZERO (exp=0,man=0), DENORM (exp=0,man!=0),
//    NORMAL, INF (exp=FF,man=0), NAN (exp=FF,man!=0). With FTZ=1, DENORM is stored as ZERO with sign kept.
//  - Special result, priority order; s = sign_a ^ sign_b:
//    1. either NaN               -> 32'h7FC0_0000 (canonical qNaN, sign 0)
//    2. Inf x ZERO (either order) -> 32'h7FC0_0000
//    3. either Inf               -> {s, 8'hFF, 23'h0}
//    4. either ZERO              -> {s, 31'h0}
//    5. otherwise out_special=0, out_special_res=0
//  - special_cnt increments on pop of an entry with out_special=1 and saturates at all-ones.
//    cnt_clr has priority over increment in the same cycle.
//  - Overflow and underflow of normal*normal products are not handled here; they are handled by the multiplier.
// STRUCTURE
//  - Package fpu_sp_pkg: typedef enum logic [2:0] fp_class_e {FP_ZERO,FP_DENORM,FP_NORMAL,FP_INF,FP_NAN};
//    localparams FP_EXP_W=8, FP_MAN_W=23, FP_QNAN=32'h7FC0_0000, FP_EXP_MAX=8'hFF.
//  - Sub-module fpu_sp_classify (combinational): 32-bit operand -> fp_class_e plus FTZ-adjusted operand.
//    Instantiate twice, once per operand, on the push path.
//  - FIFO storage is an array of structs {a, b, special, special_res}; there is no reset on the data array.
// TESTING
//  1. Reset, push 4.2f/3.2f, out_ready=1 -> out_valid next cycle, out_a=32'h40866666, out_special=0.
//  2. Push 5 pairs with out_ready=0, DEPTH=4 -> in_ready=0 after 4th push, 5th not accepted;
//     drain -> entries appear in FIFO order.
//  3. Push NaN(7FC00001)*1.0, Inf*0, -Inf*2.0, -0.0*3.0 -> special_res 7FC00000, 7FC00000,
//     FF800000, 80000000; special_cnt=4 after draining.
//  4. FTZ=1: push 32'h80000001 * 2.0 -> out_a=32'h80000000, special=1, res=32'h80000000.
//     FTZ=0: out_a=32'h80000001, special=0.
//  5. Count=2, push+pop every cycle for 10 cycles -> count stays 2, pointers wrap, no loss or duplication.
//  6. rst_n=0 with 3 entries queued -> out_valid=0 and in_ready=1 next cycle; special_cnt saturates at
//     16'hFFFF; cnt_clr together with a special pop -> special_cnt=0.

Source files
------------

// File: rtl/fpu_sp_pkg.sv
// Shared single-precision FP types and helpers for the multiplier front end.
package fpu_sp_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;

  localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC0_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // One staged operand pair with its precomputed bypass result.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            special;
    logic [FP_W-1:0] special_res;
  } fp_entry_t;

  // {special, result} for a product given both operand classes and the product sign.
  // A DENORM class here is one that was not flushed, so it behaves as a normal number.
  function automatic logic [FP_W:0] fp_special_res(input fp_class_e ca,
                                                   input fp_class_e cb,
                                                   input logic      s);
    logic [FP_W:0] r;
    r = '0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      r = {1'b1, FP_QNAN};
    end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
      r = {1'b1, FP_QNAN};
    end else if (ca == FP_INF || cb == FP_INF) begin
      r = {1'b1, s, FP_EXP_MAX, FP_MAN_W'(0)};
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      r = {1'b1, s, (FP_W-1)'(0)};
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_sp_classify.sv
// Classifies one single-precision operand and applies flush-to-zero.
//   op     : raw IEEE-754 bit pattern
//   cls    : operand class after flushing (a flushed denormal reports FP_ZERO)
//   op_ftz : operand after flushing (sign kept)
module fpu_sp_classify
  import fpu_sp_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic [FP_W-1:0] op,
  output fp_class_e       cls,
  output logic [FP_W-1:0] op_ftz
);

  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_MAN_W-1:0] man_f;

  assign exp_f = op[FP_W-2 -: FP_EXP_W];
  assign man_f = op[FP_MAN_W-1:0];

  always_comb begin
    cls    = FP_NORMAL;
    op_ftz = op;
    if (exp_f == '0) begin
      if (man_f == '0) begin
        cls = FP_ZERO;
      end else if (FTZ) begin
        cls    = FP_ZERO;
        op_ftz = {op[FP_W-1], (FP_W-1)'(0)};
      end else begin
        cls = FP_DENORM;
      end
    end else if (exp_f == FP_EXP_MAX) begin
      cls = (man_f == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fpu_sp_mul_operand_stage.sv
// Operand staging FIFO ahead of the SP multiplier; classifies and precomputes specials on push.
//   in_valid/in_ready/in_a/in_b       : producer handshake and operands
//   out_valid/out_ready/out_a/out_b   : head entry to the multiplier (zeros while empty)
//   out_special/out_special_res       : head bypass flag and final result
//   special_cnt/cnt_clr               : saturating count of popped specials, synchronous clear
module fpu_sp_mul_operand_stage
  import fpu_sp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter bit          FTZ   = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_a,
  output logic [FP_W-1:0]  out_b,
  output logic             out_special,
  output logic [FP_W-1:0]  out_special_res,
  output logic [CNT_W-1:0] special_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  fp_entry_t        mem [DEPTH];
  fp_entry_t        head, push_entry;
  fp_class_e        cls_a, cls_b;
  logic [FP_W-1:0]  a_ftz, b_ftz;
  logic [FP_W:0]    spec;
  logic             push, pop;

  fpu_sp_classify #(.FTZ(FTZ)) u_cls_a (.op(in_a), .cls(cls_a), .op_ftz(a_ftz));
  fpu_sp_classify #(.FTZ(FTZ)) u_cls_b (.op(in_b), .cls(cls_b), .op_ftz(b_ftz));

  // Build the entry on the push path so the pop side only reads storage.
  always_comb begin
    spec       = fp_special_res(cls_a, cls_b, in_a[FP_W-1] ^ in_b[FP_W-1]);
    push_entry = '{a: a_ftz, b: b_ftz, special: spec[FP_W], special_res: spec[FP_W-1:0]};
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Control state; in_ready/out_valid are flops loaded from the next count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      special_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      in_ready  <= (count_nxt != FULL_CNT);
      out_valid <= (count_nxt != '0);
      if (cnt_clr) begin
        special_cnt <= '0;
      end else if (pop && head.special && (special_cnt != '1)) begin
        special_cnt <= special_cnt + CNT_W'(1);
      end
    end
  end

  // Data storage, no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign out_a           = out_valid ? head.a           : '0;
  assign out_b           = out_valid ? head.b           : '0;
  assign out_special     = out_valid ? head.special     : 1'b0;
  assign out_special_res = out_valid ? head.special_res : '0;

endmodule
